// File: rtl/cpu6_pc_ctrl.sv
// cpu6 program counter and next-PC control.
// Resolves branches/jumps from EX and drives the fetch request.
module cpu6_pc_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] alu_y,
  input  logic            alu_zero,
  input  logic            br_valid,
  input  logic [1:0]      br_type,
  input  logic            br_is_jalr,
  input  logic [XLEN-1:0] br_target,
  input  logic            stall,
  input  logic            if_req_ready,
  output logic            if_req_valid,
  output logic [XLEN-1:0] if_req_addr,
  output logic            flush,
  output logic            exc_misalign,
  output logic [XLEN-1:0] exc_addr
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            valid_q, valid_d;
  logic            flush_q, flush_d;
  logic            exc_q, exc_d;
  logic [XLEN-1:0] exc_addr_q, exc_addr_d;

  logic            accept;
  logic            taken;
  logic            aligned;
  logic            redir_ok;
  logic [XLEN-1:0] target;

  // Branch resolution: condition, target select, alignment.
  always_comb begin
    taken = 1'b0;
    unique case (br_type)
      2'b01:   taken = alu_zero;
      2'b10:   taken = !alu_zero;
      2'b11:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
    taken    = taken & br_valid;
    target   = (br_type == 2'b11 && br_is_jalr)
             ? (alu_y & ~XLEN'(1)) : br_target;
    aligned  = (target[1:0] == 2'b00);
    accept   = valid_q & if_req_ready;
    redir_ok = (state_q != BOOT) & taken & aligned;
  end

  // Next-state: FSM, fetch valid, PC priority, pending target, pulses.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    flush_d    = 1'b0;
    exc_d      = 1'b0;
    exc_addr_d = exc_addr_q;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        valid_d = !stall;
      end
      default: begin
        valid_d = (accept || !valid_q) ? !stall : 1'b1;
        if (taken && !aligned) begin
          exc_d      = 1'b1;
          exc_addr_d = target;
        end
        if (redir_ok) begin
          flush_d = 1'b1;
          if (!valid_q || accept) begin
            pc_d    = target;
            state_d = RUN;
          end else begin
            pend_d  = target;
            state_d = REDIR;
          end
        end else if (state_q == REDIR && accept) begin
          pc_d    = pend_q;
          state_d = RUN;
        end else if (accept) begin
          pc_d = pc_q + XLEN'(4);
        end
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      exc_q      <= 1'b0;
      exc_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      valid_q    <= valid_d;
      flush_q    <= flush_d;
      exc_q      <= exc_d;
      exc_addr_q <= exc_addr_d;
    end
  end

  assign if_req_valid = valid_q;
  assign if_req_addr  = pc_q;
  assign flush        = flush_q;
  assign exc_misalign = exc_q;
  assign exc_addr     = exc_addr_q;

endmodule
